// File: rtl/dft4_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dft_pkg
// Shared definitions for the 4-point DFT blocks: widths, FSM state encoding,
// Q1.15 twiddle constants and the accumulator-to-Q1.15 saturation helper.
// No ports (package).
// -----------------------------------------------------------------------------
package dft_pkg;

    localparam int DATA_W = 16;
    // Four products of two Q1.15 values fit with two guard bits.
    localparam int ACC_W  = 2 * DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // e^{-j*2*pi*idx/4} expressed as cos / sin in Q1.15 (+1 rounded to 32767).
    localparam logic signed [DATA_W-1:0] COS_Q15 [4] = '{16'sd32767, 16'sd0, -16'sd32767, 16'sd0};
    localparam logic signed [DATA_W-1:0] SIN_Q15 [4] = '{16'sd0, 16'sd32767, 16'sd0, -16'sd32767};

    // Clamp an already-shifted accumulator value into signed DATA_W range.
    // The value fits iff all bits above the DATA_W sign bit equal the MSB.
    function automatic logic signed [DATA_W-1:0] sat_q15(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-DATA_W-1:0] upper;
        upper = a[ACC_W-2:DATA_W-1];
        if (!a[ACC_W-1] && (|upper)) begin
            sat_q15 = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (a[ACC_W-1] && !(&upper)) begin
            sat_q15 = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_q15 = a[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/dft4_sequencer_if.sv
// -----------------------------------------------------------------------------
// dft4_sequencer_if
// Frame-request and bin-output bus of the 4-point DFT sequencer.
//   start, x0..x3 : frame request and samples (master -> slave)
//   bin_ready     : consumer ready (master -> slave)
//   busy, bin_valid, bin_k, bin_re, bin_im, done : status/results (slave -> master)
// -----------------------------------------------------------------------------
interface dft4_sequencer_if;
    import dft_pkg::*;

    logic                     start;
    logic signed [DATA_W-1:0] x0;
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] x3;
    logic                     busy;
    logic                     bin_valid;
    logic                     bin_ready;
    logic [1:0]               bin_k;
    logic signed [DATA_W-1:0] bin_re;
    logic signed [DATA_W-1:0] bin_im;
    logic                     done;

    modport master (
        output start, x0, x1, x2, x3, bin_ready,
        input  busy, bin_valid, bin_k, bin_re, bin_im, done
    );

    modport slave (
        input  start, x0, x1, x2, x3, bin_ready,
        output busy, bin_valid, bin_k, bin_re, bin_im, done
    );

endinterface

// File: rtl/dft4_sequencer_twiddle_rom.sv
// -----------------------------------------------------------------------------
// dft4_twiddle_rom
// Combinational twiddle lookup for 4-point DFTs.
//   i_idx : (k*n) mod 4
//   o_cos : Q1.15 cosine of the twiddle angle
//   o_sin : Q1.15 sine of the twiddle angle
// -----------------------------------------------------------------------------
module dft4_twiddle_rom
    import dft_pkg::*;
(
    input  logic [1:0]               i_idx,
    output logic signed [DATA_W-1:0] o_cos,
    output logic signed [DATA_W-1:0] o_sin
);

    // Table lookup of the twiddle pair.
    always_comb begin
        o_cos = COS_Q15[i_idx];
        o_sin = SIN_Q15[i_idx];
    end

endmodule

// File: rtl/dft4_sequencer.sv
// -----------------------------------------------------------------------------
// dft4_sequencer
// Computes a 4-point DFT of real Q1.15 samples with one shared multiply pair,
// iterating over all (k, n) and streaming the four complex bins out.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dft4_sequencer_if.slave (start/x0..x3 in, bins + status out)
// -----------------------------------------------------------------------------
module dft4_sequencer
    import dft_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    dft4_sequencer_if.slave bus
);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [1:0]               r_k;
    logic [1:0]               r_n;
    logic signed [DATA_W-1:0] r_x [4];
    logic signed [ACC_W-1:0]  r_acc_re;
    logic signed [ACC_W-1:0]  r_acc_im;
    logic signed [DATA_W-1:0] r_bin_re;
    logic signed [DATA_W-1:0] r_bin_im;
    logic [1:0]               r_bin_k;
    logic                     r_busy;
    logic                     r_bin_valid;
    logic                     r_done;

    logic                     w_start_frame;
    logic                     w_accumulate;
    logic                     w_next_bin;
    logic [3:0]               w_kn;
    logic [1:0]               w_tw_idx;
    logic signed [DATA_W-1:0] w_cos;
    logic signed [DATA_W-1:0] w_sin;
    logic signed [DATA_W-1:0] w_x_n;
    logic signed [2*DATA_W-1:0] w_prod_re;
    logic signed [2*DATA_W-1:0] w_prod_im;
    logic signed [ACC_W-1:0]  w_acc_re_nxt;
    logic signed [ACC_W-1:0]  w_acc_im_nxt;
    logic signed [ACC_W-1:0]  w_shift_re;
    logic signed [ACC_W-1:0]  w_shift_im;

    // Twiddle index only needs the low two bits of k*n (mod 4).
    assign w_kn     = {2'b00, r_k} * {2'b00, r_n};
    assign w_tw_idx = w_kn[1:0];

    dft4_twiddle_rom u_rom (
        .i_idx (w_tw_idx),
        .o_cos (w_cos),
        .o_sin (w_sin)
    );

    assign w_x_n        = r_x[r_n];
    assign w_prod_re    = w_x_n * w_cos;
    assign w_prod_im    = w_x_n * w_sin;
    assign w_acc_re_nxt = r_acc_re + ACC_W'(w_prod_re);
    assign w_acc_im_nxt = r_acc_im - ACC_W'(w_prod_im);
    // Output values are taken from the sums that include the n=3 term,
    // so the output regs are ready on the first OUT cycle.
    assign w_shift_re   = w_acc_re_nxt >>> 5'd15;
    assign w_shift_im   = w_acc_im_nxt >>> 5'd15;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        w_next_state  = r_state;
        w_start_frame = 1'b0;
        w_accumulate  = 1'b0;
        w_next_bin    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state  = ST_RUN;
                    w_start_frame = 1'b1;
                end else begin
                    w_next_state  = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_accumulate = 1'b1;
                if (r_n == 2'd3) begin
                    w_next_state = ST_OUT;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_OUT: begin
                if (bus.bin_ready) begin
                    if (r_k == 2'd3) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_RUN;
                        w_next_bin   = 1'b1;
                    end
                end else begin
                    w_next_state = ST_OUT;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Counters, sample capture, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k         <= 2'd0;
            r_n         <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= '0;
            end
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_bin_re    <= '0;
            r_bin_im    <= '0;
            r_bin_k     <= 2'd0;
            r_busy      <= 1'b0;
            r_bin_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Status flags track the state being entered.
            r_busy      <= (w_next_state != ST_IDLE);
            r_bin_valid <= (w_next_state == ST_OUT);
            r_done      <= (w_next_state == ST_DONE);
            if (w_start_frame) begin
                r_x[0]   <= bus.x0;
                r_x[1]   <= bus.x1;
                r_x[2]   <= bus.x2;
                r_x[3]   <= bus.x3;
                r_k      <= 2'd0;
                r_n      <= 2'd0;
                r_acc_re <= '0;
                r_acc_im <= '0;
            end else if (w_accumulate) begin
                r_acc_re <= w_acc_re_nxt;
                r_acc_im <= w_acc_im_nxt;
                r_n      <= r_n + 2'd1;
                if (r_n == 2'd3) begin
                    r_bin_re <= sat_q15(w_shift_re);
                    r_bin_im <= sat_q15(w_shift_im);
                    r_bin_k  <= r_k;
                end else begin
                    r_bin_re <= r_bin_re;
                end
            end else if (w_next_bin) begin
                r_k      <= r_k + 2'd1;
                r_n      <= 2'd0;
                r_acc_re <= '0;
                r_acc_im <= '0;
            end else begin
                r_k <= r_k;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.bin_valid = r_bin_valid;
    assign bus.bin_k     = r_bin_k;
    assign bus.bin_re    = r_bin_re;
    assign bus.bin_im    = r_bin_im;
    assign bus.done      = r_done;

endmodule
